spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
Write-only SPI transmitter driving a serial display controller (OLED command/data stream). It accepts an 8-bit or 32-bit word on a one-cycle request strobe and shifts it out MSB first. Each byte is a separate chip-select frame. There is no MISO path and no busy output; the upstream controller paces requests by watching cs.

Parameters:
SCLK_DIVIDER, 20, sclk period in clk cycles; must be even and >= 4; half-period H = SCLK_DIVIDER/2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
is_data_ready  input  1  one-cycle request strobe; sampled on clk rising edge.
is_data_width_8  input  1  1 = send data[7:0] only; 0 = send all 32 bits as four bytes.
data  input  32  word to transmit; latched together with the width flag.
mosi  output  1  serial data, MSB first.
sclk  output  1  serial clock; idles high.
cs  output  1  chip select, active low.

Behaviour:
- Reset (reset=0, async): cs=1, sclk=1, mosi=0, state IDLE, counters cleared, latched data cleared. Reset mid-frame aborts immediately with no partial completion. Operation resumes on the first clk edge after reset=1.
- SPI mode 3 (CPOL=1, CPHA=1):
  - mosi changes only with cs falling or sclk falling.
  - Slave samples on sclk rising.
  - All outputs are registered.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - cs=1, sclk=1, mosi=0.
  - On a clk edge with is_data_ready=1: latch data and is_data_width_8; byte count = 1 or 4; enter SHIFT.
  - At that same edge: cs goes 0 and mosi = MSB of the first byte. Latency from strobe is 1 edge.
- Byte order: 8-bit mode sends data[7:0]. 32-bit mode sends data[31:24], [23:16], [15:8], [7:0].
- SHIFT (one byte frame) is 17 phases of H clk cycles each, with cs=0 throughout:
  - P0: sclk=1, mosi=bit7.
  - For k=1..8: P(2k-1): sclk=0, mosi=bit(8-k). P(2k): sclk=1, same bit.
  - The rising sclk at the start of P(2k) is the sample point for bit(8-k).
  - cs is low for exactly 17*H clk cycles. Exactly 8 sclk rising edges per frame.
- End of frame: cs=1, sclk=1, mosi=0.
  - Bytes remaining: enter GAP.
  - Last byte: enter IDLE.
- GAP: cs high for exactly H clk cycles, then the next frame starts as from IDLE (cs=0, mosi = MSB of next byte).
- A new request is accepted on the first clk edge in IDLE, i.e. one cycle after cs rises on the final byte. There is no minimum idle time.
- is_data_ready asserted in SHIFT or GAP is ignored. The latched data is unaffected by changes on data or is_data_width_8 during a transfer.
- Holding is_data_ready high continuously restarts a transfer on each IDLE entry. Each accepted strobe produces exactly one word.
- Counters: phase counter 0..H-1, phase index 0..16, byte counter 0..3. No wrap beyond these ranges.

Test Plan:
- Reset: hold reset=0 for 20 cycles with random strobes -> cs=1, sclk=1, mosi=0 throughout; no sclk activity.
- 8-bit, SCLK_DIVIDER=20, data=0x03, strobe one cycle:
  - cs falls at the strobe edge and stays low 170 cycles.
  - 8 sclk rises, spaced 20 cycles apart.
  - mosi sampled on the rises = 0,0,0,0,0,0,1,1.
  - cs returns high.
- Back-to-back 8-bit: sweep data = 3, 16, 29 … up to <0xFF in steps of 13, each strobed 2 cycles after cs rises -> every word is transmitted; no dropped or duplicated frames.
- 32-bit, data=0x00340003, width flag=0:
  - Four cs-low frames of 170 cycles each, separated by 10-cycle cs-high gaps.
  - Bytes received: 0x00, 0x34, 0x00, 0x03.
- Strobe during busy: pulse is_data_ready mid-frame with different data -> ignored; the original word completes unchanged, with no extra frame.
- Async reset mid-frame (after 3 bits): cs=1, sclk=1, mosi=0 immediately, before the next clk edge. After release, a new strobe transmits the full byte correctly.

Source files
------------

// File: rtl/spi_master.sv
// Write-only SPI master, mode 3, MSB first, one cs frame per byte.
// Feeds a serial display controller with 8- or 32-bit command/data words.
module spi_master #(
    parameter int SCLK_DIVIDER = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_data_ready,
    input  logic        is_data_width_8,
    input  logic [31:0] data,
    output logic        mosi,
    output logic        sclk,
    output logic        cs
);

    localparam int H = SCLK_DIVIDER / 2;
    localparam int CW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);
    localparam logic [4:0] IDX_LAST = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state, state_d;

    logic [CW-1:0] cnt, cnt_d;
    logic [4:0]    idx, idx_d;
    logic [1:0]    left, left_d;
    logic [31:0]   word, word_d;
    logic          cs_d, sclk_d, mosi_d;

    logic [7:0] cur_byte;
    logic       phase_end;
    logic       frame_end;

    // Bytes go out from the top of the word down; 8-bit mode starts at left=0.
    assign cur_byte  = word[{left, 3'b000} +: 8];
    assign phase_end = (cnt == CNT_LAST);
    assign frame_end = (state == SHIFT) && phase_end && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            left  <= '0;
            word  <= '0;
            cs    <= 1'b1;
            sclk  <= 1'b1;
            mosi  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            left  <= left_d;
            word  <= word_d;
            cs    <= cs_d;
            sclk  <= sclk_d;
            mosi  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (is_data_ready) state_d = SHIFT;
            end
            SHIFT: begin
                if (frame_end) state_d = (left != 2'd0) ? GAP : IDLE;
            end
            GAP: begin
                if (phase_end) state_d = SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt;
        idx_d  = idx;
        left_d = left;
        word_d = word;
        cs_d   = cs;
        sclk_d = sclk;
        mosi_d = mosi;
        case (state)
            IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                left_d = '0;
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                mosi_d = 1'b0;
                if (is_data_ready) begin
                    word_d = data;
                    left_d = is_data_width_8 ? 2'd0 : 2'd3;
                    cs_d   = 1'b0;
                    mosi_d = is_data_width_8 ? data[7] : data[31];
                end
            end
            SHIFT: begin
                if (!phase_end) begin
                    cnt_d = cnt + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (idx == IDX_LAST) begin
                        idx_d  = '0;
                        cs_d   = 1'b1;
                        sclk_d = 1'b1;
                        mosi_d = 1'b0;
                        if (left != 2'd0) left_d = left - 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                        // Even->odd phase is the sclk falling edge: new bit here.
                        if (!idx[0]) begin
                            sclk_d = 1'b0;
                            mosi_d = cur_byte[3'd7 - idx[3:1]];
                        end else begin
                            sclk_d = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (!phase_end) begin
                    cnt_d = cnt + 1'b1;
                end else begin
                    cnt_d  = '0;
                    idx_d  = '0;
                    cs_d   = 1'b0;
                    sclk_d = 1'b1;
                    mosi_d = cur_byte[7];
                end
            end
            default: begin
                cnt_d  = '0;
                idx_d  = '0;
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                mosi_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a negedge monitor decodes frames from the
// pins and the stimulus compares them with hand-computed bytes and timings.
module tb_spi_master;

    localparam int DIV = 20;
    localparam int HALF = DIV / 2;

    logic        clk;
    logic        reset;
    logic        is_data_ready;
    logic        is_data_width_8;
    logic [31:0] data;
    logic        mosi;
    logic        sclk;
    logic        cs;

    int n_tests;
    int n_fail;

    logic [7:0] byte_q[$];
    int         len_q[$];
    int         nbits_q[$];
    int         gap_q[$];

    int         cyc;
    int         last_rise;
    int         cur_len;
    int         cur_n;
    int         hi_cnt;
    int         spacing_err;
    int         idle_err;
    logic [7:0] cur_bits;
    logic       cs_prev;
    logic       sclk_prev;

    spi_master #(.SCLK_DIVIDER(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .is_data_ready(is_data_ready),
        .is_data_width_8(is_data_width_8),
        .data(data),
        .mosi(mosi),
        .sclk(sclk),
        .cs(cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            cur_len  = 0;
            cur_n    = 0;
            cur_bits = '0;
            hi_cnt   = 0;
        end else if (!cs) begin
            if (cs_prev) gap_q.push_back(hi_cnt);
            cur_len++;
            if (sclk && !sclk_prev) begin
                if (cur_n > 0 && cyc - last_rise != DIV) spacing_err++;
                last_rise = cyc;
                cur_bits  = {cur_bits[6:0], mosi};
                cur_n++;
            end
        end else begin
            if (!cs_prev) begin
                byte_q.push_back(cur_bits);
                len_q.push_back(cur_len);
                nbits_q.push_back(cur_n);
                cur_len  = 0;
                cur_n    = 0;
                cur_bits = '0;
                hi_cnt   = 1;
            end else begin
                hi_cnt++;
            end
            if (!sclk || mosi) idle_err++;
        end
        cs_prev   = cs;
        sclk_prev = sclk;
    end

    task automatic clr();
        @(posedge clk);
        #1;
        byte_q.delete();
        len_q.delete();
        nbits_q.delete();
        gap_q.delete();
        spacing_err = 0;
        idle_err    = 0;
    endtask

    // Caller must be off the clock edge; strobe is sampled at next posedge.
    task automatic send(input logic [31:0] d, input logic w8);
        data            = d;
        is_data_width_8 = w8;
        is_data_ready   = 1'b1;
        @(posedge clk);
        #1;
        check("cs_fall", {31'b0, cs}, 32'd0);
        check("mosi_msb", {31'b0, mosi}, {31'b0, (w8 ? d[7] : d[31])});
        is_data_ready = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (byte_q.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (byte_q.size() < n) check("frame_timeout", byte_q.size(), n);
    endtask

    initial begin
        logic [7:0] exp_b[$];
        n_tests         = 0;
        n_fail          = 0;
        cyc             = 0;
        last_rise       = 0;
        spacing_err     = 0;
        idle_err        = 0;
        cs_prev         = 1'b1;
        sclk_prev       = 1'b1;
        reset           = 1'b0;
        is_data_ready   = 1'b0;
        is_data_width_8 = 1'b1;
        data            = '0;

        // reset held with random strobes
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            is_data_ready   = 1'($urandom_range(0, 1));
            is_data_width_8 = 1'($urandom_range(0, 1));
            data            = $urandom;
            #1;
            check("reset_pins", {29'b0, cs, sclk, mosi}, 32'b110);
        end
        @(negedge clk);
        is_data_ready = 1'b0;
        reset         = 1'b1;
        clr();

        // single 8-bit word 0x03
        send(32'h03, 1'b1);
        wait_frames(1, 400);
        check("b8_byte", {24'b0, byte_q[0]}, 32'h03);
        check("b8_len", len_q[0], 17 * HALF);
        check("b8_nbits", nbits_q[0], 8);
        check("b8_spacing", spacing_err, 0);

        // back-to-back sweep, strobe 2 cycles after cs rises
        clr();
        exp_b.delete();
        for (int d = 3; d < 255; d += 13) begin
            exp_b.push_back(8'(d));
            send(32'(d), 1'b1);
            wait_frames(exp_b.size(), 400);
            @(posedge clk);
            #1;
        end
        repeat (5) @(negedge clk);
        #1;
        check("b2b_count", byte_q.size(), 20);
        for (int i = 0; i < exp_b.size() && i < byte_q.size(); i++)
            check($sformatf("b2b_byte%0d", i), {24'b0, byte_q[i]},
                  {24'b0, exp_b[i]});
        check("b2b_spacing", spacing_err, 0);
        check("b2b_idle", idle_err, 0);

        // 32-bit word as four frames
        clr();
        send(32'h00340003, 1'b0);
        wait_frames(4, 1000);
        if (byte_q.size() == 4 && gap_q.size() == 4) begin
            check("w32_b0", {24'b0, byte_q[0]}, 32'h00);
            check("w32_b1", {24'b0, byte_q[1]}, 32'h34);
            check("w32_b2", {24'b0, byte_q[2]}, 32'h00);
            check("w32_b3", {24'b0, byte_q[3]}, 32'h03);
            for (int i = 0; i < 4; i++)
                check($sformatf("w32_len%0d", i), len_q[i], 17 * HALF);
            for (int i = 1; i < 4; i++)
                check($sformatf("w32_gap%0d", i), gap_q[i], HALF);
        end else begin
            check("w32_frames", byte_q.size(), 4);
        end
        check("w32_spacing", spacing_err, 0);
        check("w32_idle", idle_err, 0);

        // new strobe on the very first idle edge after cs rises
        clr();
        send(32'h81, 1'b1);
        wait_frames(1, 400);
        send(32'h7E, 1'b1);
        wait_frames(2, 400);
        check("imm_count", byte_q.size(), 2);
        check("imm_b0", {24'b0, byte_q[0]}, 32'h81);
        check("imm_b1", {24'b0, byte_q[1]}, 32'h7E);
        check("imm_gap", gap_q[1], 1);

        // strobe while busy is ignored
        clr();
        send(32'hA5, 1'b1);
        repeat (60) @(negedge clk);
        data            = 32'h5A5A5A5A;
        is_data_width_8 = 1'b0;
        is_data_ready   = 1'b1;
        @(negedge clk);
        is_data_ready = 1'b0;
        data          = 32'h0;
        wait_frames(1, 400);
        repeat (250) @(negedge clk);
        #1;
        check("busy_count", byte_q.size(), 1);
        check("busy_byte", {24'b0, byte_q[0]}, 32'hA5);
        check("busy_cs_idle", {31'b0, cs}, 32'd1);

        // async reset after 3 bits, then a clean byte
        clr();
        send(32'hC3, 1'b1);
        begin
            int c;
            c = 0;
            while (cur_n < 3 && c < 200) begin
                @(negedge clk);
                #1;
                c++;
            end
            check("rst_reach3", cur_n, 3);
        end
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_pins", {29'b0, cs, sclk, mosi}, 32'b110);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clr();
        send(32'h96, 1'b1);
        wait_frames(1, 400);
        check("rst_count", byte_q.size(), 1);
        check("rst_byte", {24'b0, byte_q[0]}, 32'h96);
        check("rst_len", len_q[0], 17 * HALF);
        check("rst_nbits", nbits_q[0], 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
